// File: rtl/twin_reg_arbiter_pkg.sv
// Shared types and constants for the twin register arbiter slice.
package twin_reg_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic REQ0   = 1'b0;
  localparam logic REQ1   = 1'b1;
  localparam logic SEL_Q1 = 1'b0;
  localparam logic SEL_Q2 = 1'b1;

  function automatic logic [1:0] grant_state(input logic id);
    return (id == REQ1) ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/twin_reg_arbiter_if.sv
// Two-requester bus into the arbiter: request side plus grant/read return path.
interface twin_reg_arbiter_if #(parameter int WIDTH = 8);

  logic             req0, lock0, we0, addr0;
  logic [WIDTH-1:0] wdata0;
  logic             req1, lock1, we1, addr1;
  logic [WIDTH-1:0] wdata1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rid;

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    input  gnt0, gnt1, rdata, rvalid, rid
  );

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    output gnt0, gnt1, rdata, rvalid, rid
  );

endinterface

// File: rtl/twin_reg_arbiter_bank.sv
// The q1/q2 register pair: independent load enables, shared data input.
module twin_reg_bank
  import twin_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld1,
  input  logic             ld2,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      if (ld1) q1 <= d;
      if (ld2) q2 <= d;
    end
  end

endmodule

// File: rtl/twin_reg_arbiter.sv
// Round-robin arbiter with bounded lock in front of the twin register bank.
module twin_reg_arbiter
  import twin_reg_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_LOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  twin_reg_arbiter_if.slave bus,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [1:0]    S_IDLE   = IDLE;
  localparam logic [1:0]    S_GRANT0 = GRANT0;
  localparam logic [1:0]    S_GRANT1 = GRANT1;
  localparam logic [CW-1:0] LOCK_LIM = CW'(MAX_LOCK - 1);

  logic [1:0]            state, state_nx;
  logic                  ptr, ptr_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [1:0]            req, lock, we, adr;
  logic [1:0][WIDTH-1:0] wd;
  logic                  granted, cur, oth, acc, rd;
  logic                  ld1, ld2;
  logic [WIDTH-1:0]      rmux;

  assign req = {bus.req1,   bus.req0};
  assign lock = {bus.lock1, bus.lock0};
  assign we  = {bus.we1,    bus.we0};
  assign adr = {bus.addr1,  bus.addr0};
  assign wd  = {bus.wdata1, bus.wdata0};

  assign granted = (state == S_GRANT0) || (state == S_GRANT1);
  assign cur     = (state == S_GRANT1) ? REQ1 : REQ0;
  assign oth     = ~cur;
  assign acc     = granted && req[cur];
  assign rd      = acc && !we[cur];
  assign ld1     = acc && we[cur] && (adr[cur] == SEL_Q1);
  assign ld2     = acc && we[cur] && (adr[cur] == SEL_Q2);
  assign rmux    = (adr[cur] == SEL_Q2) ? q2 : q1;

  assign bus.gnt0 = (state == S_GRANT0);
  assign bus.gnt1 = (state == S_GRANT1);

  // Leaving a grant: lock extension first, then hand-over, re-grant, idle.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (req[0] && req[1]) state_nx = grant_state(ptr);
        else if (req[0])      state_nx = S_GRANT0;
        else if (req[1])      state_nx = S_GRANT1;
      end
      S_GRANT0, S_GRANT1: begin
        if (req[cur] && lock[cur] && (cnt < LOCK_LIM)) begin
          cnt_nx = cnt + 1'b1;
        end else begin
          cnt_nx = '0;
          ptr_nx = oth;
          if (req[oth])      state_nx = grant_state(oth);
          else if (req[cur]) state_nx = grant_state(cur);
          else               state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= REQ0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end

  // rdata holds its last value; only rvalid marks a fresh read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.rid    <= REQ0;
    end else begin
      bus.rvalid <= rd;
      if (rd) begin
        bus.rdata <= rmux;
        bus.rid   <= cur;
      end
    end
  end

  twin_reg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .ld1 (ld1),
    .ld2 (ld2),
    .d   (wd[cur]),
    .q1  (q1),
    .q2  (q2)
  );

endmodule

// File: tb/tb_twin_reg_arbiter.sv
// Directed vectors, corner sequences and random traffic against a tenure-level model.
module tb_twin_reg_arbiter;

  localparam int MAX_LOCK = 4;

  logic       clk;
  logic       rst;
  logic [7:0] q1, q2;

  twin_reg_arbiter_if #(.WIDTH(8)) bus ();

  twin_reg_arbiter #(.WIDTH(8), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .q1  (q1),
    .q2  (q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 1'b1;

  // Model: who holds the registers, how long this tenure has run, who is next.
  int         m_own;
  int         m_len;
  int         m_prio;
  logic [7:0] m_q [2];
  logic [7:0] m_rdata;
  logic       m_rvalid;
  logic       m_rid;

  typedef struct {
    logic r0, l0, w0, a0; logic [7:0] d0;
    logic r1, l1, w1, a1; logic [7:0] d1;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [27:0] act_v();
    return {bus.gnt0, bus.gnt1, bus.rvalid, bus.rid, bus.rdata, q1, q2};
  endfunction

  function automatic logic [27:0] exp_v();
    return {(m_own == 0), (m_own == 1), m_rvalid, m_rid, m_rdata, m_q[0], m_q[1]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_len = 0; m_prio = 0;
    m_q[0] = 8'h00; m_q[1] = 8'h00;
    m_rdata = 8'h00; m_rvalid = 1'b0; m_rid = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] r, l, w, a;
    logic [1:0][7:0] d;
    int n, o;
    r = {bus.req1, bus.req0};   l = {bus.lock1, bus.lock0};
    w = {bus.we1, bus.we0};     a = {bus.addr1, bus.addr0};
    d = {bus.wdata1, bus.wdata0};
    m_rvalid = 1'b0;
    if (m_own >= 0) begin
      n = m_own; o = 1 - n;
      if (r[n]) begin
        if (w[n]) m_q[a[n]] = d[n];
        else begin m_rdata = m_q[a[n]]; m_rvalid = 1'b1; m_rid = n[0]; end
      end
      if (r[n] && l[n] && m_len < MAX_LOCK) m_len++;
      else begin
        m_prio = o; m_len = 1;
        m_own  = r[o] ? o : (r[n] ? n : -1);
      end
    end else begin
      if (r[0] && r[1]) m_own = m_prio;
      else if (r[0])    m_own = 0;
      else if (r[1])    m_own = 1;
      m_len = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    if (model_on) begin
      chk("model", 64'(act_v()), 64'(exp_v()));
      chk("gnt_excl", 64'(bus.gnt0 & bus.gnt1), 64'd0);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0 = v.r0; bus.lock0 = v.l0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
    bus.req1 = v.r1; bus.lock1 = v.l1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
  endtask

  initial begin
    int cnt;
    vec_t z;
    z = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 28'h0};
    // {gnt0,gnt1,rvalid,rid} rdata q1 q2
    tbl[0] = '{1'b1,1'b0,1'b1,1'b0,8'hAA, 1'b0,1'b0,1'b0,1'b0,8'h00, {4'b1000,8'h00,8'h00,8'h00}};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b0,8'hAA, 1'b0,1'b0,1'b0,1'b0,8'h00, {4'b1000,8'h00,8'hAA,8'h00}};
    tbl[2] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00, {4'b0000,8'h00,8'hAA,8'h00}};
    tbl[3] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00, {4'b0100,8'h00,8'hAA,8'h00}};
    tbl[4] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00, {4'b0111,8'hAA,8'hAA,8'h00}};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00, {4'b0001,8'hAA,8'hAA,8'h00}};
    tbl[6] = '{1'b1,1'b0,1'b1,1'b1,8'h55, 1'b1,1'b0,1'b1,1'b0,8'h0F, {4'b1001,8'hAA,8'hAA,8'h00}};
    tbl[7] = '{1'b1,1'b0,1'b1,1'b1,8'h55, 1'b1,1'b0,1'b1,1'b0,8'h0F, {4'b0101,8'hAA,8'hAA,8'h55}};
    tbl[8] = '{1'b1,1'b0,1'b1,1'b1,8'h55, 1'b1,1'b0,1'b1,1'b0,8'h0F, {4'b1001,8'hAA,8'h0F,8'h55}};
    tbl[9] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00, {4'b0001,8'hAA,8'h0F,8'h55}};

    // Reset with the clock running; outputs must clear before any edge.
    drive(z);
    rst = 1'b1;
    model_reset();
    #3;
    chk("reset_state", 64'(act_v()), 64'd0);
    #7 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("vec%0d", i), 64'(act_v()), 64'(tbl[i].exp));
    end

    // Locked burst while requester 1 waits: exactly MAX_LOCK grants to 0.
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 1'b0; bus.wdata0 = 8'h11;
    tick();
    chk("lock_first_gnt0", 64'(bus.gnt0), 64'd1);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 1'b1;
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!bus.gnt0) break;
      cnt++;
    end
    chk("lock_len", 64'(cnt), 64'(MAX_LOCK));
    chk("lock_handover", 64'(bus.gnt1), 64'd1);

    // Asynchronous reset between edges in the middle of a locked tenure.
    bus.req1 = 1'b0;
    for (int k = 0; k < 10 && !bus.gnt0; k++) tick();
    chk("regain_gnt0", 64'(bus.gnt0), 64'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async", 64'(act_v()), 64'd0);
    #4 rst = 1'b0;
    chk("rst_release_nogrant", 64'(bus.gnt0), 64'd0);
    tick();
    chk("regrant_latency", 64'(bus.gnt0), 64'd1);

    for (int k = 0; k < 400; k++) begin
      bus.req0   = ($urandom_range(0, 9) < 7);
      bus.lock0  = ($urandom_range(0, 9) < 4);
      bus.we0    = 1'($urandom);
      bus.addr0  = 1'($urandom);
      bus.wdata0 = 8'($urandom);
      bus.req1   = ($urandom_range(0, 9) < 7);
      bus.lock1  = ($urandom_range(0, 9) < 4);
      bus.we1    = 1'($urandom);
      bus.addr1  = 1'($urandom);
      bus.wdata1 = 8'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
